// File: rtl/gemm_ctrl_pkg.sv
// Shared types and defaults for the GEMM tile control path: sequencer state
// encoding, default operand-read and MAC pipeline latencies, accumulator width.
package gemm_ctrl_pkg;

    localparam int GEMM_RD_LAT  = 1;
    localparam int GEMM_MAC_LAT = 2;
    localparam int GEMM_ACC_W   = 32;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLEAR = 3'd1,
        ST_RUN   = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } mac_seq_state_t;

    // Cycles between the last operand issue and the accumulator being final.
    function automatic int drain_cycles(input int rd_lat, input int mac_lat);
        return rd_lat + mac_lat;
    endfunction

endpackage

// File: rtl/sig_delay.sv
// N-stage registered delay line with synchronous clear; every stage is
// reset by rst_n (active-low) or flushed by clr.
module sig_delay #(
    parameter int N = 1,
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] tap [0:N];

    assign tap[0] = d;

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_stage
            logic [W-1:0] stage_reg;

            always_ff @(posedge clk) begin
                if (!rst_n || clr) begin
                    stage_reg <= '0;
                end else begin
                    stage_reg <= tap[gi];
                end
            end

            assign tap[gi+1] = stage_reg;
        end
    endgenerate

    assign q = tap[N];

endmodule

// File: rtl/mac_seq_ctrl.sv
// Dot-product sequencer for one INT8 MAC lane: issues operand reads, MAC
// clear/enable and drain, returns the accumulator. Optional perf counters: MAC_SEQ_PERF_EN.
module mac_seq_ctrl
    import gemm_ctrl_pkg::*;
#(
    parameter int ACC_W   = GEMM_ACC_W,
    parameter int ADDR_W  = 12,
    parameter int K_W     = 12,
    parameter int RD_LAT  = GEMM_RD_LAT,
    parameter int MAC_LAT = GEMM_MAC_LAT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [K_W-1:0]    k_len,
    input  logic [ADDR_W-1:0] a_base,
    input  logic [ADDR_W-1:0] b_base,
    input  logic [ADDR_W-1:0] a_stride,
    input  logic [ADDR_W-1:0] b_stride,
    input  logic              stall,
    input  logic              abort,
    output logic              a_rd_en,
    output logic              b_rd_en,
    output logic [ADDR_W-1:0] a_addr,
    output logic [ADDR_W-1:0] b_addr,
    output logic              mac_clear,
    output logic              mac_en,
    input  logic [ACC_W-1:0]  acc_in,
    output logic              busy,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [ACC_W-1:0]  res_data,
    output logic [31:0]       perf_busy_cyc,
    output logic [31:0]       perf_stall_cyc
);

    localparam int DRAIN_LEN = drain_cycles(RD_LAT, MAC_LAT);
    localparam int DRAIN_W   = $clog2(DRAIN_LEN + 1);

    mac_seq_state_t    state_reg;
    logic [K_W-1:0]    k_len_reg;
    logic [K_W-1:0]    issued_reg;
    logic [ADDR_W-1:0] a_addr_reg;
    logic [ADDR_W-1:0] b_addr_reg;
    logic [ADDR_W-1:0] a_stride_reg;
    logic [ADDR_W-1:0] b_stride_reg;
    logic [DRAIN_W-1:0] drain_cnt_reg;
    logic              mac_clear_reg;
    logic              res_valid_reg;
    logic [ACC_W-1:0]  res_data_reg;

    logic              rd_en;
    logic              job_abort;
    logic [K_W-1:0]    issued_next;
    logic              mac_en_dly;

    assign job_abort   = abort && (state_reg != ST_IDLE);
    assign issued_next = issued_reg + K_W'(1);

    // Read strobe follows stall combinationally so a stalled cycle never issues.
    always_comb begin
        rd_en = 1'b0;
        if (!job_abort) begin
            case (state_reg)
                ST_CLEAR: rd_en = (k_len_reg != '0);
                ST_RUN:   rd_en = !stall;
                default:  rd_en = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg     <= ST_IDLE;
            k_len_reg     <= '0;
            issued_reg    <= '0;
            a_addr_reg    <= '0;
            b_addr_reg    <= '0;
            a_stride_reg  <= '0;
            b_stride_reg  <= '0;
            drain_cnt_reg <= '0;
            mac_clear_reg <= 1'b0;
            res_valid_reg <= 1'b0;
            res_data_reg  <= '0;
        end else if (job_abort) begin
            state_reg     <= ST_IDLE;
            mac_clear_reg <= 1'b0;
            res_valid_reg <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (start) begin
                        k_len_reg     <= k_len;
                        a_addr_reg    <= a_base;
                        b_addr_reg    <= b_base;
                        a_stride_reg  <= a_stride;
                        b_stride_reg  <= b_stride;
                        issued_reg    <= '0;
                        mac_clear_reg <= 1'b1;
                        state_reg     <= ST_CLEAR;
                    end
                end

                ST_CLEAR: begin
                    mac_clear_reg <= 1'b0;
                    if (rd_en) begin
                        a_addr_reg <= a_addr_reg + a_stride_reg;
                        b_addr_reg <= b_addr_reg + b_stride_reg;
                        issued_reg <= issued_next;
                    end
                    if (k_len_reg <= K_W'(1)) begin
                        drain_cnt_reg <= DRAIN_W'(DRAIN_LEN - 1);
                        state_reg     <= ST_DRAIN;
                    end else begin
                        state_reg <= ST_RUN;
                    end
                end

                ST_RUN: begin
                    if (rd_en) begin
                        a_addr_reg <= a_addr_reg + a_stride_reg;
                        b_addr_reg <= b_addr_reg + b_stride_reg;
                        issued_reg <= issued_next;
                        if (issued_next == k_len_reg) begin
                            drain_cnt_reg <= DRAIN_W'(DRAIN_LEN - 1);
                            state_reg     <= ST_DRAIN;
                        end
                    end
                end

                ST_DRAIN: begin
                    if (drain_cnt_reg == '0) begin
                        res_data_reg  <= acc_in;
                        res_valid_reg <= 1'b1;
                        state_reg     <= ST_DONE;
                    end else begin
                        drain_cnt_reg <= drain_cnt_reg - DRAIN_W'(1);
                    end
                end

                ST_DONE: begin
                    if (res_ready) begin
                        res_valid_reg <= 1'b0;
                        state_reg     <= ST_IDLE;
                    end
                end

                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    // MAC enable lines up with the operand data returned RD_LAT cycles later.
    sig_delay #(
        .N (RD_LAT),
        .W (1)
    ) u_en_dly (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (job_abort),
        .d     (rd_en),
        .q     (mac_en_dly)
    );

    assign a_rd_en   = rd_en;
    assign b_rd_en   = rd_en;
    assign a_addr    = a_addr_reg;
    assign b_addr    = b_addr_reg;
    assign mac_clear = mac_clear_reg;
    assign mac_en    = mac_en_dly;
    assign busy      = (state_reg != ST_IDLE);
    assign res_valid = res_valid_reg;
    assign res_data  = res_data_reg;

`ifdef MAC_SEQ_PERF_EN
    logic [31:0] perf_busy_reg;
    logic [31:0] perf_stall_reg;

    // Saturating counters, restarted by each accepted job.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            perf_busy_reg  <= '0;
            perf_stall_reg <= '0;
        end else if (state_reg == ST_IDLE && start) begin
            perf_busy_reg  <= '0;
            perf_stall_reg <= '0;
        end else begin
            if (busy && !(&perf_busy_reg)) begin
                perf_busy_reg <= perf_busy_reg + 32'd1;
            end
            if (state_reg == ST_RUN && stall && !(&perf_stall_reg)) begin
                perf_stall_reg <= perf_stall_reg + 32'd1;
            end
        end
    end

    assign perf_busy_cyc  = perf_busy_reg;
    assign perf_stall_cyc = perf_stall_reg;
`else
    assign perf_busy_cyc  = 32'd0;
    assign perf_stall_cyc = 32'd0;
`endif

endmodule

// File: doc/mac_seq_ctrl.md
Name: mac_seq_ctrl

Overview:
- Sequencer for one INT8 MAC lane: takes a dot-product job (length, operand base addresses, strides) and issues operand-buffer reads, MAC clear/enable, and pipeline drain.
- Returns the 32-bit accumulated result over a valid/ready handshake.
- Sits between the GEMM tile scheduler and the mac_int8 instance plus its two operand SRAMs.

Parameters:
- ACC_W, 32, accumulator/result width (matches the MAC).
- ADDR_W, 12, operand-buffer address width.
- K_W, 12, width of the job length field.
- RD_LAT, 1, operand SRAM read latency in cycles (must be >= 1).
- MAC_LAT, 2, MAC pipeline depth in cycles (enable to acc_out visible).

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- start  in  1  job request; sampled only in IDLE
- k_len  in  K_W  number of products; 0 is legal
- a_base  in  ADDR_W  first A address
- b_base  in  ADDR_W  first B address
- a_stride  in  ADDR_W  A address increment
- b_stride  in  ADDR_W  B address increment
- stall  in  1  operand source not ready; pauses issue in RUN
- abort  in  1  cancel current job
- a_rd_en  out  1  A read strobe
- b_rd_en  out  1  B read strobe (always equals a_rd_en)
- a_addr  out  ADDR_W  A read address
- b_addr  out  ADDR_W  B read address
- mac_clear  out  1  to MAC clear_acc
- mac_en  out  1  to MAC en
- acc_in  in  ACC_W  from MAC acc_out
- busy  out  1  state != IDLE
- res_valid  out  1  result available
- res_ready  in  1  consumer accepts result
- res_data  out  ACC_W  registered result
- perf_busy_cyc  out  32  optional counter
- perf_stall_cyc  out  32  optional counter

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-low on rst_n, sampled on the rising edge of clk.
- Reset values: all outputs 0; state IDLE.
- States: IDLE, CLEAR, RUN, DRAIN, DONE.
- IDLE:
  - start=1 latches k_len, bases and strides, and moves to CLEAR.
  - start in any other state is ignored.
- CLEAR (exactly 1 cycle):
  - mac_clear=1.
  - If k_len>0: rd_en=1 at the base addresses; issued count becomes 1. stall is ignored in CLEAR.
  - Next state: DRAIN if k_len<=1, else RUN.
- RUN:
  - rd_en = !stall.
  - On each issue, both addresses advance by their strides, wrapping modulo 2^ADDR_W.
  - On the issue that makes count == k_len, go to DRAIN.
- mac_en:
  - mac_en is rd_en delayed by exactly RD_LAT registered cycles, so stall bubbles propagate to the MAC.
  - mac_clear always precedes the first mac_en by RD_LAT >= 1 cycles; the MAC gives clear priority, so they must never coincide.
- DRAIN:
  - Lasts RD_LAT+MAC_LAT cycles, counted from the cycle after the last issue, with no reads.
  - On its final cycle, res_data <= acc_in.
- DONE:
  - res_valid=1 and res_data held until res_valid && res_ready, then IDLE.
  - A new start in that same cycle is not accepted.
- Latency with no stalls:
  - start sampled at cycle 0, then CLEAR at 1, issues at 1..N, DRAIN at N+1..N+3, res_valid at N+4 (default parameters).
  - k_len=0 gives res_valid at cycle 5 with res_data=0.
- abort (any state except IDLE):
  - Next cycle is IDLE; rd_en, res_valid and mac_en pipeline are cleared immediately; no result is produced.
  - abort has priority over start, stall and res_ready.
- Overflow handling: the controller does no arithmetic on data; saturation is the MAC's job.
- Reset mid-job: same as abort, plus res_data is cleared.

Optional Feature:
- MAC_SEQ_PERF_EN defined:
  - perf_busy_cyc counts cycles with busy=1.
  - perf_stall_cyc counts RUN cycles with stall=1.
  - Both are 32-bit, saturate at all-ones, and clear on an accepted start.
- Not defined: both ports are tied to 0 and no counter flops exist.

Decomposition:
- Shared package gemm_ctrl_pkg holds:
  - the state enum type (mac_seq_state_t);
  - default latency constants (GEMM_RD_LAT=1, GEMM_MAC_LAT=2);
  - the ACC_W default.
- One sub-module, sig_delay: a parameterised N-cycle registered delay line with synchronous clear, used for rd_en to mac_en.

Test Plan:
- k_len=4, a_base=0x010, b_base=0x100, strides 1, no stall:
  - a_addr is 0x010..0x013 on cycles 1..4;
  - mac_clear is high only at cycle 1; mac_en is high at cycles 2..5;
  - res_valid at cycle 8; with the MAC model and A={1,2,3,4}, B={5,6,7,8}, res_data=70.
- k_len=3 with stall high on RUN cycles 2 and 3:
  - issues occur at cycles 1, 4, 5; mac_en gaps mirror them;
  - res_valid at cycle 9; perf_stall_cyc=2 when MAC_SEQ_PERF_EN is defined.
- k_len=0: no rd_en ever; res_valid at cycle 5 with res_data=0.
- a_base=0xFFE, a_stride=1, k_len=4: a_addr sequence 0xFFE, 0xFFF, 0x000, 0x001.
- Hold res_ready=0 for 10 cycles in DONE: res_valid and res_data are stable throughout and start is ignored; then res_ready=1 returns to IDLE the next cycle.
- abort asserted in RUN at cycle 3 of k_len=8: IDLE at cycle 4, mac_en low by cycle 4, res_valid never asserted; a new job then completes correctly.
